// File: rtl/multi_seq_ctrl.sv
// Sequenced WIDTH x WIDTH multiplier built around one shared 4x4 array multiplier.
// Optional macro MUL_SIGNED_EN selects two's complement operands and result.

module mul4x4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] p
);
    // Array multiplier: sum of AND-gated, shifted rows
    always_comb begin
        p = 8'd0;
        for (int k = 0; k < 4; k++) begin
            p = p + ({4'd0, x & {4{y[k]}}} << k);
        end
    end
endmodule

module multi_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 busy
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int PW  = 2 * WIDTH;
    localparam int SW  = $clog2(PW) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [PW-1:0]     acc_r;
    logic [PW-1:0]     out_r;
    logic              out_valid_r;
    logic [CW-1:0]     i_r;
    logic [CW-1:0]     j_r;
    logic              in_ready_s;
    logic              busy_s;
    logic              accept_s;
    logic              last_step_s;
    logic              j_wrap_s;
    logic [3:0]        mul_a_s;
    logic [3:0]        mul_b_s;
    logic [7:0]        pp_s;
    logic [SW-1:0]     shamt_s;
    logic [PW-1:0]     next_acc_s;
    logic [PW-1:0]     result_s;
    logic [WIDTH-1:0]  cap_a_s;
    logic [WIDTH-1:0]  cap_b_s;

`ifdef MUL_SIGNED_EN
    logic sign_r;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            magnitude = (~v) + WIDTH'(1);
        end else begin
            magnitude = v;
        end
    endfunction

    assign cap_a_s  = magnitude(a);
    assign cap_b_s  = magnitude(b);
    assign result_s = sign_r ? ((~next_acc_s) + PW'(1)) : next_acc_s;

    // Result sign is captured alongside the magnitudes
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_r <= 1'b0;
        end else if (accept_s) begin
            sign_r <= a[WIDTH-1] ^ b[WIDTH-1];
        end else begin
            sign_r <= sign_r;
        end
    end
`else
    assign cap_a_s  = a;
    assign cap_b_s  = b;
    assign result_s = next_acc_s;
`endif

    mul4x4 u_mul (
        .x (mul_a_s),
        .y (mul_b_s),
        .p (pp_s)
    );

    // Nibble selection, shift and accumulate; multiplier idles at zero outside CALC
    always_comb begin
        if (state_r == CALC) begin
            mul_a_s = a_r[4*i_r +: 4];
            mul_b_s = b_r[4*j_r +: 4];
        end else begin
            mul_a_s = 4'd0;
            mul_b_s = 4'd0;
        end
        shamt_s     = (SW'(i_r) + SW'(j_r)) << 2;
        next_acc_s  = acc_r + (PW'(pp_s) << shamt_s);
        j_wrap_s    = (j_r == CW'(NIB - 1));
        last_step_s = j_wrap_s && (i_r == CW'(NIB - 1));
    end

    // Next-state and handshake outputs; in_ready is suppressed while rst is asserted
    always_comb begin
        state_next_s = state_r;
        in_ready_s   = 1'b0;
        busy_s       = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready_s = ~rst;
                if (in_valid && !rst) begin
                    state_next_s = CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                busy_s = 1'b1;
                if (last_step_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = CALC;
                end
            end
            DONE: begin
                busy_s = 1'b1;
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        accept_s = in_valid && in_ready_s;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, accumulation, step counters and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r         <= '0;
            b_r         <= '0;
            acc_r       <= '0;
            out_r       <= '0;
            out_valid_r <= 1'b0;
            i_r         <= '0;
            j_r         <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r   <= cap_a_s;
                        b_r   <= cap_b_s;
                        acc_r <= '0;
                        i_r   <= '0;
                        j_r   <= '0;
                    end else begin
                        a_r <= a_r;
                    end
                end
                CALC: begin
                    acc_r <= next_acc_s;
                    if (last_step_s) begin
                        out_r       <= result_s;
                        out_valid_r <= 1'b1;
                        i_r         <= '0;
                        j_r         <= '0;
                    end else if (j_wrap_s) begin
                        i_r <= i_r + CW'(1);
                        j_r <= '0;
                    end else begin
                        j_r <= j_r + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign busy      = busy_s;
    assign out       = out_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_multi_seq_ctrl.sv
// Directed scoreboard bench for multi_seq_ctrl at WIDTH=8 and WIDTH=12.
// Expectations follow MUL_SIGNED_EN when the macro is defined.

module tb_multi_seq_ctrl;
    logic        clk;
    logic        rst;
    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] out8;
    logic        in_valid12, in_ready12, out_valid12, out_ready12, busy12;
    logic [11:0] a12, b12;
    logic [23:0] out12;

    int checks   = 0;
    int failures = 0;
    logic [15:0] q8[$];
    logic [23:0] q12[$];

    multi_seq_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out(out8), .busy(busy8)
    );

    multi_seq_ctrl #(.WIDTH(12)) dut12 (
        .clk(clk), .rst(rst), .in_valid(in_valid12), .in_ready(in_ready12),
        .a(a12), .b(b12), .out_valid(out_valid12), .out_ready(out_ready12),
        .out(out12), .busy(busy12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs_v, exp_v);
        end
    endtask

    task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] ev, input int hold);
        int n;
        int busy_n;
        logic [15:0] exp;
        q8.push_back(ev);
        @(negedge clk);
        chk("idle_in_ready8", in_ready8, 1'b1);
        chk("idle_busy8", busy8, 1'b0);
        a8 = av; b8 = bv; in_valid8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        n = 1; busy_n = 0;
        while (!out_valid8 && n < 30) begin
            chk("calc_in_ready8", in_ready8, 1'b0);
            if (busy8) busy_n++;
            @(negedge clk);
            n++;
        end
        if (busy8) busy_n++;
        chk("latency8", n - 1, 4);
        chk("done_in_ready8", in_ready8, 1'b0);
        exp = q8.pop_front();
        chk("out8", out8, exp);
        for (int h = 0; h < hold; h++) begin
            in_valid8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
            @(negedge clk);
            if (busy8) busy_n++;
            chk("bp_out_valid8", out_valid8, 1'b1);
            chk("bp_out8", out8, exp);
            chk("bp_in_ready8", in_ready8, 1'b0);
        end
        in_valid8 = 1'b1;
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        in_valid8 = 1'b0;
        chk("hs_out_valid8", out_valid8, 1'b0);
        chk("hs_in_ready8", in_ready8, 1'b1);
        chk("hs_busy8", busy8, 1'b0);
        chk("hs_out_hold8", out8, exp);
        if (hold == 0) begin
            chk("busy_cycles8", busy_n, 5);
        end
    endtask

    task automatic run12(input logic [11:0] av, input logic [11:0] bv, input logic [23:0] ev);
        int n;
        logic [23:0] exp;
        q12.push_back(ev);
        @(negedge clk);
        chk("idle_in_ready12", in_ready12, 1'b1);
        a12 = av; b12 = bv; in_valid12 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid12 = 1'b0;
        a12 = 12'($urandom); b12 = 12'($urandom);
        n = 1;
        while (!out_valid12 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency12", n - 1, 9);
        exp = q12.pop_front();
        chk("out12", out12, exp);
        out_ready12 = 1'b1;
        @(negedge clk);
        out_ready12 = 1'b0;
        chk("hs_out_valid12", out_valid12, 1'b0);
        chk("hs_in_ready12", in_ready12, 1'b1);
    endtask

    initial begin
        int vcount;
        rst = 1'b1;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        in_valid12 = 1'b0; out_ready12 = 1'b0; a12 = 12'd0; b12 = 12'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready8", in_ready8, 1'b0);
        chk("rst_out_valid8", out_valid8, 1'b0);
        chk("rst_busy8", busy8, 1'b0);
        chk("rst_out8", out8, 16'h0000);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready8", in_ready8, 1'b1);

`ifdef MUL_SIGNED_EN
        run8(8'h0C, 8'h0A, 16'h0078, 0);
        run8(8'hFF, 8'hFF, 16'h0001, 0);
        run8(8'h00, 8'h5A, 16'h0000, 0);
        run8(8'hFF, 8'hFF, 16'h0001, 10);
`else
        run8(8'h0C, 8'h0A, 16'h0078, 0);
        run8(8'hFF, 8'hFF, 16'hFE01, 0);
        run8(8'h00, 8'h5A, 16'h0000, 0);
        run8(8'hFF, 8'hFF, 16'hFE01, 10);
`endif

        // Abort during step 2, then confirm no output ever appears
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; in_valid8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready8", in_ready8, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("after_rst_in_ready8", in_ready8, 1'b1);
        chk("after_rst_busy8", busy8, 1'b0);
        vcount = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid8) vcount++;
        end
        chk("abort_no_valid8", vcount, 0);
        run8(8'h12, 8'h34, 16'h03A8, 0);

`ifdef MUL_SIGNED_EN
        run8(8'hFD, 8'h05, 16'hFFF1, 0);
        run8(8'h80, 8'h80, 16'h4000, 0);
        run8(8'h7F, 8'h80, 16'hC080, 0);
        run12(12'hFFF, 12'hFFF, 24'h000001);
        run12(12'h800, 12'h7FF, 24'hC00800);
`else
        run8(8'hFD, 8'h05, 16'h04F1, 0);
        run8(8'h80, 8'h80, 16'h4000, 0);
        run8(8'h7F, 8'h80, 16'h3F80, 0);
        run12(12'hFFF, 12'hFFF, 24'hFFE001);
        run12(12'h800, 12'h7FF, 24'h3FF800);
`endif

        chk("sb_empty8", q8.size(), 0);
        chk("sb_empty12", q12.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
